// File: rtl/doodle_jump_controller.sv
// Doodle Jump physics controller: vertical motion, bounces and jump counting,
// advanced once per video frame.
// Optional build macro FALL_DEATH_EN: a floor landing after the first bounce
// ends the game (DEAD, game_over=1) instead of bouncing.
module doodle_jump_controller #(
    parameter int unsigned JUMP_V     = 20,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned MAX_FALL_V = 20,
    parameter int unsigned DOODLE_H   = 80,
    parameter int unsigned START_Y    = 400,
    parameter int unsigned FLOOR_Y    = 767
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       doodle_collision,
    input  logic [9:0] ground_y,
    output logic [9:0] doodle_y,
    output logic       doodle_fall_direction,
    output logic [5:0] doodle_velocity,
    output logic [7:0] jump_count,
    output logic       game_over
);

    localparam int unsigned YW = 10;
    localparam int unsigned VW = 6;
    localparam int unsigned CW = 8;
    // Wide enough that sums and differences never wrap before clamping.
    localparam int unsigned AW = 12;

    localparam logic [AW-1:0] GROUND_TOP = AW'(FLOOR_Y - DOODLE_H);
    localparam logic [AW-1:0] GRAV_W     = AW'(GRAVITY);
    localparam logic [AW-1:0] MAXV_W     = AW'(MAX_FALL_V);
    localparam logic [AW-1:0] HEIGHT_W   = AW'(DOODLE_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } state_t;

    state_t state;

    logic [AW-1:0] y_w;
    logic [AW-1:0] v_w;
    logic [AW-1:0] gnd_w;
    logic [AW-1:0] rise_y;
    logic [AW-1:0] fall_sum;
    logic [AW-1:0] fall_y;
    logic [AW-1:0] vel_sum;
    logic [AW-1:0] fall_v;
    logic [AW-1:0] bounce_y;

    // Saturating next-position / next-velocity candidates for each phase.
    always_comb begin
        y_w      = AW'(doodle_y);
        v_w      = AW'(doodle_velocity);
        gnd_w    = AW'(ground_y);
        rise_y   = (v_w > y_w) ? '0 : (y_w - v_w);
        fall_sum = y_w + v_w;
        fall_y   = (fall_sum > GROUND_TOP) ? GROUND_TOP : fall_sum;
        vel_sum  = v_w + GRAV_W;
        fall_v   = (vel_sum > MAXV_W) ? MAXV_W : vel_sum;
        bounce_y = (gnd_w < HEIGHT_W) ? '0 : (gnd_w - HEIGHT_W);
    end

    // State machine with registered physics outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            doodle_y              <= YW'(START_Y);
            doodle_velocity       <= '0;
            doodle_fall_direction <= 1'b0;
            jump_count            <= '0;
`ifdef FALL_DEATH_EN
            game_over             <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= RISE;
                        doodle_velocity <= VW'(JUMP_V);
                    end
                end
                RISE: begin
                    if (frame_tick) begin
                        doodle_y <= YW'(rise_y);
                        if (v_w <= GRAV_W) begin
                            doodle_velocity       <= '0;
                            state                 <= FALL;
                            doodle_fall_direction <= 1'b1;
                        end else begin
                            doodle_velocity <= VW'(v_w - GRAV_W);
                        end
                    end
                end
                FALL: begin
                    if (frame_tick) begin
                        if (doodle_collision) begin
`ifdef FALL_DEATH_EN
                            if ((gnd_w >= AW'(FLOOR_Y)) && (jump_count != '0)) begin
                                state                 <= DEAD;
                                game_over             <= 1'b1;
                                doodle_velocity       <= '0;
                                doodle_y              <= YW'(GROUND_TOP);
                                doodle_fall_direction <= 1'b0;
                            end else
`endif
                            begin
                                state                 <= RISE;
                                doodle_y              <= YW'(bounce_y);
                                doodle_velocity       <= VW'(JUMP_V);
                                doodle_fall_direction <= 1'b0;
                                if (jump_count != {CW{1'b1}}) begin
                                    jump_count <= jump_count + CW'(1);
                                end
                            end
                        end else begin
                            doodle_y        <= YW'(fall_y);
                            doodle_velocity <= VW'(fall_v);
                        end
                    end
                end
                DEAD: begin
                    if (start) begin
                        state                 <= RISE;
                        doodle_y              <= YW'(START_Y);
                        doodle_velocity       <= VW'(JUMP_V);
                        doodle_fall_direction <= 1'b0;
                        jump_count            <= '0;
`ifdef FALL_DEATH_EN
                        game_over             <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef FALL_DEATH_EN
    // Without floor death the game never ends.
    assign game_over = 1'b0;
`endif

endmodule
